dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single read/write port of the data memory between two requesters: the processor load/store path and a DMA/boot loader.
- Replaces the fixed one-cycle load staller. It generates the CPU stall from both the memory read latency and port contention.
- Sits between the processor memory stage and the data memory. The load data translator stays downstream; this block supplies it the raw word and the latched byte offset.

Parameters:
ADDR_WIDTH, 32, CPU byte-address width
DATA_WIDTH, 32, memory word width
MEM_AW, 8, memory word-address width
STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA gets priority (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_en  in  1  CPU request valid; held stable while cpu_stalled=1
cpu_op  in  4  load/store op; bit 3 = store
cpu_address  in  ADDR_WIDTH  CPU byte address
cpu_writedata  in  DATA_WIDTH  store data, already byte-aligned
cpu_stalled  out  1  combinational stall to the pipeline
cpu_rdata  out  DATA_WIDTH  raw load word
cpu_rvalid  out  1  cpu_rdata valid this cycle
cpu_byteoff  out  2  cpu_address[1:0] latched at load issue
dma_req  in  1  DMA request; held until granted
dma_we  in  1  DMA write
dma_addr  in  MEM_AW  DMA word address
dma_wdata  in  DATA_WIDTH  DMA write data
dma_gnt  out  1  one-cycle pulse when the DMA access issues
dma_rdata  out  DATA_WIDTH  DMA read word
dma_rvalid  out  1  dma_rdata valid this cycle
mem_we  out  1  memory write enable
mem_addr  out  MEM_AW  memory word address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, one cycle after address

Behaviour:
- FSM states: IDLE, CPU_RD, DMA_RD. Only IDLE issues accesses.
- Reset: state=IDLE, starve counter=0, cpu_byteoff=0. While reset is high, every output is 0, including cpu_stalled.
- Reset asserted in CPU_RD or DMA_RD: the read is abandoned and no rvalid is produced.
- CPU address mapping: mem_addr = cpu_address[MEM_AW+1:2]. mem_wdata is taken from the issuing requester.
- I/O store (cpu_en, cpu_op[3]=1, cpu_address[ADDR_WIDTH-1]=1):
  - mem_we=0 and no stall.
  - Consumes no arbitration slot, so a DMA request can issue in the same cycle.
- IDLE arbitration:
  - Candidates are CPU (cpu_en, not an I/O store) and DMA (dma_req).
  - The CPU wins unless starve counter == STARVE_LIMIT, in which case the DMA wins.
- CPU store issue (cycle N):
  - mem_we=1, cpu_stalled=0.
  - Completes in N; state stays IDLE.
- CPU load issue (cycle N):
  - cpu_stalled=1 and cpu_byteoff is latched; go to CPU_RD.
  - In N+1: cpu_rvalid=1, cpu_rdata=mem_rdata, cpu_stalled=0, then return to IDLE.
  - The still-presented load in N+1 is not reissued.
- DMA issue (cycle N):
  - dma_gnt=1 in N; mem_we=dma_we.
  - For a read, go to DMA_RD; in N+1, dma_rvalid=1 and dma_rdata=mem_rdata, then return to IDLE.
- cpu_stalled=1 whenever cpu_en is high and the request is neither issued nor completing this cycle. This covers:
  - losing arbitration;
  - any cycle in DMA_RD;
  - the load-issue cycle.
- Store cycles are never stalled when the CPU wins arbitration.
- Starve counter:
  - +1 in each cycle where dma_req=1 and the DMA is not granted, saturating at STARVE_LIMIT.
  - Cleared on dma_gnt.
  - Unchanged in cycles where dma_req=0.
- Back-to-back CPU loads issue every 2 cycles. A pending DMA request is served in the IDLE cycle between them only once starved.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding (IDLE/CPU_RD/DMA_RD);
  - OP_STORE_BIT=3;
  - the CPU/DMA owner enum.
- One sub-module, dmem_starve_ctr: a saturating counter with inc/clr inputs and an at_limit output, width $clog2(STARVE_LIMIT+1).

Test Plan:
- CPU store alone: cpu_en=1, cpu_op=4'b1000, addr=0x14, data=0xDEADBEEF → in the same cycle mem_we=1, mem_addr=5, cpu_stalled=0.
- CPU load alone: memory word 5 = 0x12345678, LW addr=0x17 → stall=1 for 1 cycle; next cycle cpu_rvalid=1, cpu_rdata=0x12345678, cpu_byteoff=3; exactly one memory read.
- I/O store: addr=0x80000010 store with dma_req write addr=2 in the same cycle → mem_we=1, mem_addr=2, dma_gnt=1, no stall.
- Starvation: continuous CPU stores plus a held dma_req, STARVE_LIMIT=4 → DMA denied 4 cycles; dma_gnt in the 5th cycle with cpu_stalled=1 that cycle; counter returns to 0.
- DMA read blocks CPU: DMA read granted at N, CPU load arrives at N+1 → dma_rvalid at N+1 with the CPU stalled; CPU load issues at N+2; cpu_rvalid at N+3.
- Reset mid-load: reset asserted in CPU_RD → no cpu_rvalid, all outputs 0; after release the FSM is in IDLE and the counter is 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, port owner and
// the store bit position within the CPU op code.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_e;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_e;
  localparam int OP_STORE_BIT = 3;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// CPU, DMA and memory-side signals of the shared data-memory port.
// slave = the arbiter; master = requesters plus the memory.
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 8
);
  logic                  cpu_en;
  logic [3:0]            cpu_op;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_writedata;
  logic                  cpu_stalled;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;
  logic [1:0]            cpu_byteoff;
  logic                  dma_req;
  logic                  dma_we;
  logic [MEM_AW-1:0]     dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_rvalid;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_en, cpu_op, cpu_address, cpu_writedata,
    output cpu_stalled, cpu_rdata, cpu_rvalid, cpu_byteoff,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_en, cpu_op, cpu_address, cpu_writedata,
    input  cpu_stalled, cpu_rdata, cpu_rvalid, cpu_byteoff,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive denied DMA cycles; at_limit flips priority.
module dmem_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT+1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)                   cnt <= '0;
    else if (inc && cnt != W'(LIMIT))   cnt <= cnt + 1'b1;
  end

  assign at_limit = (cnt == W'(LIMIT));
endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU load/store path and
// a DMA engine; derives the CPU stall from read latency and port contention.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_AW       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  dmem_port_arbiter_if.slave  bus
);
  state_e     state_q, state_d;
  owner_e     owner;
  logic [1:0] byteoff_q, byteoff_d;
  logic       gnt, at_limit;
  logic       io_store, cpu_cand, is_store;

  // I/O stores are handled elsewhere; they never touch the memory port.
  assign is_store = bus.cpu_op[OP_STORE_BIT];
  assign io_store = bus.cpu_en & is_store & bus.cpu_address[ADDR_WIDTH-1];
  assign cpu_cand = bus.cpu_en & ~io_store;

  logic unused_bits;
  assign unused_bits = ^{bus.cpu_op[2:0], bus.cpu_address[ADDR_WIDTH-2:MEM_AW+2]};

  dmem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (bus.dma_req & ~gnt),
    .clr      (gnt),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      byteoff_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      byteoff_q <= byteoff_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    byteoff_d       = byteoff_q;
    owner           = OWN_CPU;
    gnt             = 1'b0;
    bus.cpu_stalled = 1'b0;
    bus.cpu_rdata   = '0;
    bus.cpu_rvalid  = 1'b0;
    bus.cpu_byteoff = 2'b00;
    bus.dma_rdata   = '0;
    bus.dma_rvalid  = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    // Reset forces every output low, including the stall.
    if (!reset) begin
      bus.cpu_byteoff = byteoff_q;
      case (state_q)
        IDLE: begin
          if (cpu_cand || bus.dma_req) begin
            owner = (cpu_cand && !(bus.dma_req && at_limit)) ? OWN_CPU : OWN_DMA;
            if (owner == OWN_CPU) begin
              bus.mem_addr  = bus.cpu_address[MEM_AW+1:2];
              bus.mem_wdata = bus.cpu_writedata;
              if (is_store) begin
                bus.mem_we = 1'b1;
              end else begin
                bus.cpu_stalled = 1'b1;
                byteoff_d       = bus.cpu_address[1:0];
                state_d         = CPU_RD;
              end
            end else begin
              gnt             = 1'b1;
              bus.mem_we      = bus.dma_we;
              bus.mem_addr    = bus.dma_addr;
              bus.mem_wdata   = bus.dma_wdata;
              bus.cpu_stalled = cpu_cand;
              if (!bus.dma_we) state_d = DMA_RD;
            end
          end
        end
        CPU_RD: begin
          bus.cpu_rvalid = 1'b1;
          bus.cpu_rdata  = bus.mem_rdata;
          state_d        = IDLE;
        end
        DMA_RD: begin
          bus.dma_rvalid  = 1'b1;
          bus.dma_rdata   = bus.mem_rdata;
          bus.cpu_stalled = cpu_cand;
          state_d         = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.dma_gnt = gnt;
endmodule
